// File: rtl/reg_mask_encoder_pkg.sv
// ============================================================================
// Module   : reg_mask_encoder_pkg
// Brief    : Shared widths and state encoding for the mask-to-address encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_mask_encoder_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_ADR_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_mask_encoder_prio_enc32.sv
// ============================================================================
// Module   : prio_enc32
// Brief    : Combinational lowest-set-bit encoder with any/single-bit flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prio_enc32
  import reg_mask_encoder_pkg::*;
(
  input  logic [REG_COUNT-1:0] i_mask,
  output logic [REG_ADR_W-1:0] o_idx,
  output logic                 o_any,
  output logic                 o_single
);

  logic [REG_COUNT-1:0] w_mask_m1;

  assign w_mask_m1 = i_mask - {{(REG_COUNT-1){1'b0}}, 1'b1};
  assign o_any     = |i_mask;
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign o_single  = o_any && ((i_mask & w_mask_m1) == '0);

  // Scan high to low so the last hit is the lowest index.
  always_comb begin
    o_idx = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = REG_ADR_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_mask_encoder.sv
// ============================================================================
// Module   : reg_mask_encoder
// Brief    : Walks a 32-bit register mask, emitting each set bit's address.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_mask_encoder
  import reg_mask_encoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_mask_valid,
  output logic                 o_mask_ready,
  input  logic [REG_COUNT-1:0] i_mask,
  input  logic                 i_flush,
  output logic                 o_adr_valid,
  input  logic                 i_adr_ready,
  output logic [REG_ADR_W-1:0] o_adr,
  output logic                 o_adr_last,
  output logic                 o_done,
  output logic                 o_busy
);

  state_t               r_state;
  logic [REG_COUNT-1:0] r_mask;
  logic                 r_done;

  logic [REG_ADR_W-1:0] w_adr;
  logic                 w_any;
  logic                 w_single;
  logic [REG_COUNT-1:0] w_mask_cleared;

  prio_enc32 u_prio_enc32 (
    .i_mask   (r_mask),
    .o_idx    (w_adr),
    .o_any    (w_any),
    .o_single (w_single)
  );

  assign w_mask_cleared = r_mask & ~({{(REG_COUNT-1){1'b0}}, 1'b1} << w_adr);

  // The remaining mask is zero whenever the block is idle, so the decoded
  // address and last flag naturally read back as zero there.
  assign o_mask_ready = (r_state == IDLE);
  assign o_busy       = (r_state == RUN);
  assign o_adr_valid  = (r_state == RUN) && w_any;
  assign o_adr        = w_adr;
  assign o_adr_last   = w_single;
  assign o_done       = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_done  <= 1'b0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_mask_valid) begin
            r_mask <= i_mask;
            if (i_mask == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (i_adr_ready) begin
            r_mask <= w_mask_cleared;
            if (w_single) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_mask  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
